// File: rtl/sample_average_buffer.sv
// sample_average_buffer
//   Buffers 32-bit unsigned samples written on din/we in an internal FIFO.
//   A ce pulse starts a call: i_average_dataNum samples (clamped to the FIFO
//   depth) are drained in write order and summed into a wide accumulator.
//   A restoring divider then produces floor(sum/N), which is returned on
//   o_average_return together with a one-cycle o_done pulse.
//
// Ports
//   clk                : system clock, rising edge
//   reset              : synchronous, active-high
//   we / din           : sample write strobe / data
//   ce                 : method-call start (accepted only when idle)
//   i_average_dataNum  : sample count for the call, latched on accepted ce
//   o_average_return   : average result, held until the next result
//   o_busy             : high from the cycle after accepted ce through o_done
//   o_done             : one-cycle result-valid pulse
//   o_count            : samples currently buffered
//   o_overflow         : sticky, a write was dropped because the FIFO was full
module sample_average_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  input  logic              ce,
  input  logic [31:0]       i_average_dataNum,
  output logic [DATA_W-1:0] o_average_return,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow
);

  localparam int unsigned   DEPTH   = 1 << ADDR_W;
  localparam int unsigned   CNT_W   = $clog2(ACC_W + 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCUM,
    S_DIVIDE,
    S_DONE
  } state_t;

  state_t state;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_en;
  logic              rd_en;

  // Call datapath
  logic [ADDR_W:0]   num;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   num_clamped;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  rem;
  logic [CNT_W-1:0]  div_cnt;
  logic [ACC_W:0]    rem_shift;
  logic [ACC_W-1:0]  divisor_ext;
  logic [ACC_W-1:0]  rem_sub;
  logic              rem_ge;

  assign wr_en   = we && (count != DEPTH_C);
  assign rd_en   = (state == S_ACCUM) && (issued != num);
  assign o_count = count;

  always_comb begin
    num_clamped = i_average_dataNum[ADDR_W:0];
    if (i_average_dataNum > 32'(DEPTH)) num_clamped = DEPTH_C;
  end

  // Restoring divider step: acc doubles as the dividend/quotient shift
  // register, so after ACC_W steps it holds floor(sum/N).
  always_comb begin
    rem_shift   = {rem, acc[ACC_W-1]};
    divisor_ext = {{(ACC_W - ADDR_W - 1){1'b0}}, num};
    rem_ge      = rem_shift >= {1'b0, divisor_ext};
    // True difference is < divisor, so the low ACC_W bits are exact.
    rem_sub     = rem_shift[ACC_W-1:0] - divisor_ext;
  end

  // RAM array and its registered read port (1-cycle latency, no reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
    if (rd_en) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (we && (count == DEPTH_C)) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      num              <= '0;
      issued           <= '0;
      acc              <= '0;
      rem              <= '0;
      div_cnt          <= '0;
      o_average_return <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          o_busy <= ce;
          if (ce) begin
            num    <= num_clamped;
            acc    <= '0;
            issued <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (num == '0)         state <= S_DONE;
          else if (count >= num) state <= S_ACCUM;
        end
        S_ACCUM: begin
          // Reads issue for N cycles; the final cycle only absorbs the
          // last RAM output, which is when rd_en has already dropped.
          if (rd_en) issued <= issued + 1'b1;
          if (rd_valid) acc <= acc + {{(ACC_W - DATA_W){1'b0}}, rd_data};
          if (!rd_en) begin
            rem     <= '0;
            div_cnt <= '0;
            state   <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          acc     <= {acc[ACC_W-2:0], rem_ge};
          rem     <= rem_ge ? rem_sub : rem_shift[ACC_W-1:0];
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CNT_W'(ACC_W - 1)) state <= S_DONE;
        end
        S_DONE: begin
          o_average_return <= acc[DATA_W-1:0];
          o_done           <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
